// File: rtl/controller_sysid_regs.sv
// controller_sysid_regs: Avalon-MM system-ID slave (ID, timestamp, scratch, coherent uptime, caps).
// Optional heartbeat down-counter and level IRQ are compiled in with SYSID_HEARTBEAT_EN.
module controller_sysid_regs #(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 3,
  parameter logic [31:0]       SYS_ID      = 32'h0000_C001,
  parameter logic [31:0]       TIMESTAMP   = 32'h5BB9_3B52,
  parameter logic [DATA_W-1:0] SCRATCH_RST = '0,
  parameter int                HB_RELOAD   = 1000000
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic              readdatavalid,
  output logic              irq
);

  if (DATA_W < 16 || DATA_W > 64) begin : g_bad_data_w
    $error("controller_sysid_regs: DATA_W must be within 16..64");
  end
  if (ADDR_W < 3 || ADDR_W > 8) begin : g_bad_addr_w
    $error("controller_sysid_regs: ADDR_W must be within 3..8");
  end
  if (HB_RELOAD < 0) begin : g_bad_hb_reload
    $error("controller_sysid_regs: HB_RELOAD must be non-negative");
  end

`ifdef SYSID_HEARTBEAT_EN
  localparam logic HB_PRESENT = 1'b1;
`else
  localparam logic HB_PRESENT = 1'b0;
`endif

  // 32-bit constants are zero-extended or truncated to the bus width
  localparam logic [31:0]       CAPS32 = {15'd0, HB_PRESENT, 4'd0, 4'(ADDR_W), 8'(DATA_W)};
  localparam logic [DATA_W-1:0] ID_W   = DATA_W'(SYS_ID);
  localparam logic [DATA_W-1:0] TS_W   = DATA_W'(TIMESTAMP);
  localparam logic [DATA_W-1:0] CAPS_W = DATA_W'(CAPS32);

  logic [DATA_W-1:0]   readdata_q, readdata_d;
  logic                rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   scratch_q, scratch_d;
  logic [2*DATA_W-1:0] uptime_q, uptime_d;
  logic [DATA_W-1:0]   shadow_q, shadow_d;
  logic [DATA_W-1:0]   hb_rdata;
  logic [7:0]          addr8;

  assign addr8 = 8'(address);

  // Read mux samples state before this edge, so a same-cycle write is seen only by later reads
  always_comb begin
    readdata_d = readdata_q;
    rvalid_d   = read;
    scratch_d  = scratch_q;
    uptime_d   = uptime_q + (2*DATA_W)'(1);
    shadow_d   = shadow_q;
    if (read) begin
      case (addr8)
        8'd0:    readdata_d = ID_W;
        8'd1:    readdata_d = TS_W;
        8'd2:    readdata_d = scratch_q;
        8'd3: begin
          readdata_d = uptime_q[DATA_W-1:0];
          shadow_d   = uptime_q[2*DATA_W-1:DATA_W];
        end
        8'd4:    readdata_d = shadow_q;
        8'd5:    readdata_d = CAPS_W;
        8'd6:    readdata_d = hb_rdata;
        default: readdata_d = '0;
      endcase
    end
    if (write && addr8 == 8'd2) begin
      scratch_d = writedata;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      readdata_q <= '0;
      rvalid_q   <= 1'b0;
      scratch_q  <= SCRATCH_RST;
      uptime_q   <= '0;
      shadow_q   <= '0;
    end else begin
      readdata_q <= readdata_d;
      rvalid_q   <= rvalid_d;
      scratch_q  <= scratch_d;
      uptime_q   <= uptime_d;
      shadow_q   <= shadow_d;
    end
  end

  assign readdata      = readdata_q;
  assign readdatavalid = rvalid_q;

`ifdef SYSID_HEARTBEAT_EN
  localparam int HB_W = (DATA_W > 32) ? DATA_W : 32;

  logic [HB_W-1:0] hb_q, hb_d;
  logic            expired_q, expired_d;

  // A write to word 6 overrides the expiry that would happen on the same edge
  always_comb begin
    hb_d      = hb_q;
    expired_d = expired_q;
    if (hb_q != '0) begin
      hb_d = hb_q - HB_W'(1);
    end
    if (hb_q == HB_W'(1)) begin
      expired_d = 1'b1;
    end
    if (write && addr8 == 8'd6) begin
      hb_d      = HB_W'(HB_RELOAD);
      expired_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hb_q      <= HB_W'(HB_RELOAD);
      expired_q <= 1'b0;
    end else begin
      hb_q      <= hb_d;
      expired_q <= expired_d;
    end
  end

  assign hb_rdata = {expired_q, hb_q[DATA_W-2:0]};
  assign irq      = expired_q;
`else
  assign hb_rdata = '0;
  assign irq      = 1'b0;
`endif

endmodule

// File: tb/tb_controller_sysid_regs.sv
// Bench for controller_sysid_regs: vector table + read scoreboard, reset/heartbeat sequences,
// and a 16-bit instance that walks the uptime counter across its low-half carry.
module tb_controller_sysid_regs;

`ifdef SYSID_HEARTBEAT_EN
  localparam logic [31:0] CAPS_EXP = 32'h0001_0320;
  localparam logic        IRQ2_EXP = 1'b1;
`else
  localparam logic [31:0] CAPS_EXP = 32'h0000_0320;
  localparam logic        IRQ2_EXP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n, reset2_n;
  logic [2:0]  address, address2;
  logic        read, write, read2, write2;
  logic [31:0] writedata, readdata;
  logic [15:0] writedata2, readdata2;
  logic        readdatavalid, readdatavalid2, irq, irq2;

  int checks = 0;
  int passed = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] data;
    int          due;
    string       name;
  } exp_t;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  exp_t sb_q[$];
  exp_t sb2_q[$];
  vec_t vecs[$];

  controller_sysid_regs #(.DATA_W(32), .ADDR_W(3), .HB_RELOAD(10)) dut (
    .clock(clock), .reset_n(reset_n), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .readdatavalid(readdatavalid), .irq(irq)
  );

  controller_sysid_regs #(.DATA_W(16), .ADDR_W(3), .HB_RELOAD(10)) dut16 (
    .clock(clock), .reset_n(reset2_n), .address(address2), .read(read2), .write(write2),
    .writedata(writedata2), .readdata(readdata2), .readdatavalid(readdatavalid2), .irq(irq2)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Each expected read must show up exactly one cycle after it was issued
  always @(negedge clock) begin
    exp_t e;
    if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
      e = sb_q.pop_front();
      check({e.name, "_rdv"}, 64'(readdatavalid), 64'd1);
      if (readdatavalid) check(e.name, 64'(readdata), 64'(e.data));
    end else if (readdatavalid) begin
      check("spurious_rdv", 64'(readdatavalid), 64'd0);
    end
  end

  always @(negedge clock) begin
    exp_t e;
    if (sb2_q.size() != 0 && sb2_q[0].due <= cyc) begin
      e = sb2_q.pop_front();
      check({e.name, "_rdv"}, 64'(readdatavalid2), 64'd1);
      if (readdatavalid2) check(e.name, 64'(readdata2), 64'(e.data));
    end else if (readdatavalid2) begin
      check("spurious_rdv16", 64'(readdatavalid2), 64'd0);
    end
  end

  task automatic drive(input logic wr, input logic rd, input logic [2:0] a,
                       input logic [31:0] wd, input logic [31:0] ex, input string nm);
    exp_t e;
    write = wr; read = rd; address = a; writedata = wd;
    if (rd) begin
      e.data = ex; e.due = cyc + 1; e.name = nm;
      sb_q.push_back(e);
    end
    @(negedge clock);
    write = 1'b0; read = 1'b0;
  endtask

  task automatic drive16(input logic [2:0] a, input logic [15:0] ex, input string nm);
    exp_t e;
    read2 = 1'b1; address2 = a;
    e.data = 32'(ex); e.due = cyc + 1; e.name = nm;
    sb2_q.push_back(e);
    @(negedge clock);
    read2 = 1'b0;
  endtask

  task automatic add_vec(input logic wr, input logic rd, input logic [2:0] a,
                         input logic [31:0] wd, input logic [31:0] ex, input string nm);
    vec_t v;
    v.wr = wr; v.rd = rd; v.addr = a; v.wdata = wd; v.exp = ex; v.name = nm;
    vecs.push_back(v);
  endtask

  initial begin
    add_vec(0, 1, 3'd0, 32'h0,         32'h0000_C001, "sys_id");
    add_vec(0, 1, 3'd1, 32'h0,         32'h5BB9_3B52, "timestamp");
    add_vec(0, 1, 3'd5, 32'h0,         CAPS_EXP,      "caps");
    add_vec(1, 0, 3'd2, 32'hA5A5_5A5A, 32'h0,         "wr_scratch");
    add_vec(0, 1, 3'd2, 32'h0,         32'hA5A5_5A5A, "scratch");
    add_vec(1, 1, 3'd2, 32'h0000_1234, 32'hA5A5_5A5A, "read_before_write");
    add_vec(0, 1, 3'd2, 32'h0,         32'h0000_1234, "scratch_new");
    add_vec(1, 0, 3'd0, 32'hFFFF_FFFF, 32'h0,         "wr_id");
    add_vec(1, 0, 3'd1, 32'hFFFF_FFFF, 32'h0,         "wr_ts");
    add_vec(1, 0, 3'd3, 32'hFFFF_FFFF, 32'h0,         "wr_uptime");
    add_vec(1, 0, 3'd5, 32'hFFFF_FFFF, 32'h0,         "wr_caps");
    add_vec(1, 0, 3'd7, 32'hFFFF_FFFF, 32'h0,         "wr_unmapped");
    add_vec(0, 1, 3'd0, 32'h0,         32'h0000_C001, "sys_id_ro");
    add_vec(0, 1, 3'd1, 32'h0,         32'h5BB9_3B52, "timestamp_ro");
    add_vec(0, 1, 3'd5, 32'h0,         CAPS_EXP,      "caps_ro");
    add_vec(0, 1, 3'd7, 32'h0,         32'h0,         "unmapped7");
    add_vec(0, 1, 3'd2, 32'h0,         32'h0000_1234, "scratch_kept");
`ifndef SYSID_HEARTBEAT_EN
    add_vec(0, 1, 3'd6, 32'h0,         32'h0,         "heartbeat_absent");
`endif

    reset_n = 1'b0; reset2_n = 1'b0;
    read = 1'b0; write = 1'b0; address = '0; writedata = '0;
    read2 = 1'b0; write2 = 1'b0; address2 = '0; writedata2 = '0;
    repeat (3) @(negedge clock);
    check("rst_readdata", 64'(readdata), 64'd0);
    check("rst_rdv", 64'(readdatavalid), 64'd0);
    check("rst_irq", 64'(irq), 64'd0);
    reset_n = 1'b1;
    @(negedge clock);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, vecs[i].exp, vecs[i].name);
    end
    repeat (2) @(negedge clock);
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    // Reset pulse while a read is on the bus: no valid may follow
    read = 1'b1; address = 3'd2;
    #2 reset_n = 1'b0;
    @(negedge clock);
    read = 1'b0;
    reset_n = 1'b1;
    check("midrst_rdv0", 64'(readdatavalid), 64'd0);
    @(negedge clock);
    check("midrst_rdv1", 64'(readdatavalid), 64'd0);
    drive(0, 1, 3'd2, 32'h0, 32'h0, "scratch_after_reset");

`ifdef SYSID_HEARTBEAT_EN
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (9) @(negedge clock);
    check("irq_before_expiry", 64'(irq), 64'd0);
    @(negedge clock);
    check("irq_at_expiry", 64'(irq), 64'd1);
    drive(0, 1, 3'd6, 32'h0, 32'h8000_0000, "hb_expired");
    drive(1, 0, 3'd6, 32'hDEAD_BEEF, 32'h0, "wr_hb");
    check("irq_cleared", 64'(irq), 64'd0);
    repeat (9) @(negedge clock);
    check("irq_before_race", 64'(irq), 64'd0);
    drive(1, 0, 3'd6, 32'h0, 32'h0, "wr_hb_race");
    check("irq_race_write_wins", 64'(irq), 64'd0);
    drive(0, 1, 3'd6, 32'h0, 32'h0000_000A, "hb_reloaded");
    check("irq_after_reload", 64'(irq), 64'd0);
`endif

    // 16-bit instance: walk the uptime counter up to its low-half carry
    reset2_n = 1'b1;
    repeat (16'hFFFE) @(negedge clock);
    drive16(3'd3, 16'hFFFE, "uptime_lo_pre");
    drive16(3'd4, 16'h0000, "uptime_hi_pre");
    drive16(3'd3, 16'h0000, "uptime_lo_post");
    drive16(3'd4, 16'h0001, "uptime_hi_post");
    repeat (2) @(negedge clock);
    check("sb16_drained", 64'(sb2_q.size()), 64'd0);
    check("sb_final_drained", 64'(sb_q.size()), 64'd0);
    check("irq16", 64'(irq2), 64'(IRQ2_EXP));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/controller_sysid_regs.md
Name: controller_sysid_regs

Overview:
- Parametrised system-identification slave on the controller Avalon-MM bus; the next generation of the fixed two-word ID/timestamp slave.
- Returns build ID and timestamp, plus:
  - a writable scratch register for bus sanity checks;
  - a coherent free-running uptime counter;
  - a capabilities word.
- Registered read path with readdatavalid. Sits beside the other control slaves; software probes it first at boot.

Parameters:
- SYS_ID, 32'h0000C001, value returned at word 0.
- TIMESTAMP, 32'h5BB9_3B52, build time (epoch seconds) returned at word 1.
- DATA_W, 32, bus data width; legal 16..64.
- ADDR_W, 3, word address width; legal 3..8.
- SCRATCH_RST, 0, reset value of the scratch register.
- HB_RELOAD, 1000000, heartbeat countdown reload value; used only with the optional feature.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  ADDR_W  word address.
- read  in  1  read strobe, one cycle per access.
- write  in  1  write strobe, one cycle per access.
- writedata  in  DATA_W  write data.
- readdata  out  DATA_W  registered read data.
- readdatavalid  out  1  high one cycle when readdata is valid.
- irq  out  1  heartbeat-expired interrupt; constant 0 without the optional feature.

Behaviour:
- Reset (async assert, sync release):
  - readdata=0, readdatavalid=0, irq=0.
  - Scratch = SCRATCH_RST; uptime = 0; shadow = 0.
  - Heartbeat counter = HB_RELOAD; expired flag = 0.
- No waitrequest. Every access is accepted in the cycle it is presented.
- Read latency is fixed at 1:
  - read at edge N gives readdatavalid=1 and readdata at edge N+1;
  - otherwise readdatavalid=0 and readdata holds its last value.
- Register map (word addresses):
  - 0 = SYS_ID (RO).
  - 1 = TIMESTAMP (RO).
  - 2 = SCRATCH (RW).
  - 3 = UPTIME_LO (RO). A read also copies uptime[2*DATA_W-1:DATA_W] into the shadow register in the same cycle.
  - 4 = UPTIME_HI shadow (RO). Holds the value captured by the last word-3 read.
  - 5 = CAPS (RO):
    - [7:0] = DATA_W;
    - [11:8] = ADDR_W;
    - [16] = 1 if the heartbeat is compiled in;
    - other bits 0.
  - 6 = HEARTBEAT (RW with feature, else reads 0).
  - 7 and above read 0.
- Write behaviour:
  - Writes to RO or unmapped words are ignored.
  - Constants narrower than DATA_W are zero-extended; wider ones are truncated to DATA_W.
- Uptime counter:
  - Width 2*DATA_W; increments every clock.
  - Wraps from all-ones to 0 with no flag.
  - The word-3 read returns the low half and latches the high half from the same counter sample, so the LO/HI pair is coherent across a carry.
- Read and write in the same cycle:
  - both are performed;
  - the read returns the pre-write value (read-before-write).
- Reset asserted mid-access: the pending readdatavalid is dropped, with no stale pulse after release.

Optional Feature:
- Macro: SYSID_HEARTBEAT_EN.
- With the macro:
  - A down-counter loads HB_RELOAD at reset and on any write to word 6; writedata is ignored.
  - It decrements each clock while nonzero.
  - On reaching 0, the expired flag sets and irq=1; irq is level, driven from the flag register.
  - A write to word 6 clears the flag and reloads the counter. When this write coincides with the counter reaching 0, the write wins and irq stays 0.
  - Word 6 reads {expired, counter[DATA_W-2:0]}.
- Without the macro: no counter logic; irq tied 0; word 6 reads 0; CAPS[16]=0.

Test Plan:
- Reset release, read words 0,1,5 back-to-back with defaults -> readdata 0x0000C001, 0x5BB93B52, 0x00000320, each with one-cycle readdatavalid; CAPS reads 0x00010320 when built with the macro.
- Write 0xA5A5_5A5A to word 2 then read it -> 0xA5A55A5A. Same-cycle read+write of 0x1234 to word 2 -> returns 0xA5A55A5A; a next read returns 0x00001234.
- Force the uptime counter to 0x0000_0000_FFFF_FFFE and read word 3 then word 4 across the carry -> LO 0xFFFFFFFE, HI 0x00000000 (coherent). Repeat the pair after the carry -> HI 0x00000001.
- Write 0xFFFFFFFF to words 0,1,3,5 and 7 -> subsequent reads are unchanged (ID/TS/CAPS constants, 7 reads 0).
- Macro on with HB_RELOAD=10 -> irq rises 10 cycles after reset. A write to word 6 drops irq the next cycle. A write on the expiry cycle keeps irq 0.
- Assert reset_n low for 1 cycle between read and readdatavalid -> no readdatavalid pulse; scratch returns to SCRATCH_RST.
